bcd_serial_sub: RTL and testbench

//  Digit-serial, multi-digit BCD subtractor: computes A - B over NDIG packed BCD digits, LSD first, one digit per clock.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_add.sv | 17 +
 rtl/bcd_serial_sub.sv | 137 +++++++++++++
 tb/tb_bcd_serial_sub.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit-serial subtractor: digit width, FSM encoding
// and the nine's-complement helper.
package bcd_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

   function automatic logic [BCD_W-1:0] nines(input logic [BCD_W-1:0] d);
      return BCD_MAX - d;
   endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with +6 correction; operands are always valid digits 0..9.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic             cin,
   input  logic [BCD_W-1:0] x,
   input  logic [BCD_W-1:0] y,
   output logic             cout,
   output logic [BCD_W-1:0] s
);
   logic [BCD_W:0] z, zc;

   assign z  = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, cin};
   // Sums of 10..19 wrap past the 4-bit boundary once 6 is added, giving carry + digit
   assign zc = (z < (BCD_W+1)'(10)) ? z : z + (BCD_W+1)'(6);
   assign {cout, s} = zc;
endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor: A - B by ten's complement, LSD first, one digit per clock.
// A negative raw result is re-complemented in a second pass to yield magnitude plus sign.
module bcd_serial_sub
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BCD_W*NDIG-1:0] a,
   input  logic [BCD_W*NDIG-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [BCD_W*NDIG-1:0] diff,
   output logic                  neg,
   output logic                  err
);
   localparam int W  = BCD_W * NDIG;
   localparam int CW = $clog2(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d, neg_q, neg_d, err_q, err_d;
   logic            in_err, add_c;
   logic [BCD_W-1:0] add_x, add_y, add_s;
   logic [W-1:0]    r_shift;

   always_comb begin
      in_err = 1'b0;
      for (int i = 0; i < NDIG; i++)
         if (a[i*BCD_W +: BCD_W] > BCD_MAX || b[i*BCD_W +: BCD_W] > BCD_MAX) in_err = 1'b1;
   end

   // Single adder shared by both passes: SUB adds A + 9-B, NEG adds 0 + 9-R
   assign add_x = (state_q == SUB) ? a_q[BCD_W-1:0] : '0;
   assign add_y = nines((state_q == SUB) ? b_q[BCD_W-1:0] : r_q[BCD_W-1:0]);

   bcd_digit_add u_add (
      .cin  (carry_q),
      .x    (add_x),
      .y    (add_y),
      .cout (add_c),
      .s    (add_s)
   );

   assign r_shift = {add_s, r_q[W-1:BCD_W]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      diff_d  = diff_q;
      neg_d   = neg_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_d     = a;
               b_d     = b;
               r_d     = '0;
               carry_d = 1'b1;
               cnt_d   = '0;
               err_d   = in_err;
               neg_d   = 1'b0;
               diff_d  = '0;
               state_d = in_err ? DONE : SUB;
            end
         end
         SUB: begin
            a_d     = a_q >> BCD_W;
            b_d     = b_q >> BCD_W;
            r_d     = r_shift;
            carry_d = add_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (add_c) begin
                  diff_d  = r_shift;
                  state_d = DONE;
               end else begin
                  carry_d = 1'b1;
                  state_d = NEG;
               end
            end
         end
         NEG: begin
            r_d     = r_shift;
            carry_d = add_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               diff_d  = r_shift;
               neg_d   = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         diff_q  <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         diff_q  <= diff_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q == SUB) || (state_q == NEG);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign neg  = neg_q;
   assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed bench for bcd_serial_sub (NDIG=4): results, sign, error path, latency and control.
module tb_bcd_serial_sub;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] a, b, diff;
   logic        busy, done, neg, err;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   bcd_serial_sub #(.NDIG(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err)
   );

   always #5 clk = ~clk;

   // Pulses start for one cycle, then waits (bounded) for done; returns latency and busy cycles
   task automatic do_op(input logic [15:0] av, input logic [15:0] bv, output int lat, output int bcyc);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 1; bcyc = 0;
      while (!done && lat < 40) begin
         if (busy) bcyc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset done got %b exp 0", done); else pass_cnt++;
      total_cnt++; if (neg  !== 1'b0) $display("FAIL reset neg got %b exp 0", neg);   else pass_cnt++;
      total_cnt++; if (err  !== 1'b0) $display("FAIL reset err got %b exp 0", err);   else pass_cnt++;
      total_cnt++; if (diff !== 16'h0000) $display("FAIL reset diff got %h exp 0000", diff); else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic [15:0] va [8] = '{16'h5432, 16'h1234, 16'h1000, 16'h0000, 16'h9999, 16'h0000, 16'h9999, 16'h0000};
      logic [15:0] vb [8] = '{16'h1234, 16'h5432, 16'h0001, 16'h0001, 16'h9999, 16'h0000, 16'h0000, 16'h9999};
      logic [15:0] ed [8] = '{16'h4198, 16'h4198, 16'h0999, 16'h0001, 16'h0000, 16'h0000, 16'h9999, 16'h9999};
      logic        en [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      int lat, bcyc, el;
      for (int i = 0; i < 8; i++) begin
         do_op(va[i], vb[i], lat, bcyc);
         el = en[i] ? 9 : 5;
         total_cnt++; if (lat  !== el)    $display("FAIL basic[%0d] latency got %0d exp %0d", i, lat, el); else pass_cnt++;
         total_cnt++; if (bcyc !== el-1)  $display("FAIL basic[%0d] busy cycles got %0d exp %0d", i, bcyc, el-1); else pass_cnt++;
         total_cnt++; if (diff !== ed[i]) $display("FAIL basic[%0d] diff got %h exp %h", i, diff, ed[i]); else pass_cnt++;
         total_cnt++; if (neg  !== en[i]) $display("FAIL basic[%0d] neg got %b exp %b", i, neg, en[i]); else pass_cnt++;
         total_cnt++; if (err  !== 1'b0)  $display("FAIL basic[%0d] err got %b exp 0", i, err); else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++; if (done !== 1'b0)  $display("FAIL basic[%0d] done width got %b exp 0", i, done); else pass_cnt++;
         total_cnt++; if (diff !== ed[i]) $display("FAIL basic[%0d] diff hold got %h exp %h", i, diff, ed[i]); else pass_cnt++;
      end
   endtask

   task automatic test_err;
      int lat, bcyc;
      do_op(16'h00A0, 16'h0001, lat, bcyc);
      total_cnt++; if (lat  !== 1)        $display("FAIL err latency got %0d exp 1", lat); else pass_cnt++;
      total_cnt++; if (err  !== 1'b1)     $display("FAIL err flag got %b exp 1", err); else pass_cnt++;
      total_cnt++; if (diff !== 16'h0000) $display("FAIL err diff got %h exp 0000", diff); else pass_cnt++;
      total_cnt++; if (neg  !== 1'b0)     $display("FAIL err neg got %b exp 0", neg); else pass_cnt++;
      do_op(16'h0005, 16'h0003, lat, bcyc);
      total_cnt++; if (err  !== 1'b0)     $display("FAIL err clear got %b exp 0", err); else pass_cnt++;
      total_cnt++; if (diff !== 16'h0002) $display("FAIL err next diff got %h exp 0002", diff); else pass_cnt++;
      total_cnt++; if (lat  !== 5)        $display("FAIL err next latency got %0d exp 5", lat); else pass_cnt++;
      do_op(16'h0001, 16'hF000, lat, bcyc);
      total_cnt++; if (err  !== 1'b1)     $display("FAIL err b-digit got %b exp 1", err); else pass_cnt++;
      total_cnt++; if (lat  !== 1)        $display("FAIL err b-digit latency got %0d exp 1", lat); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored;
      int lat;
      a = 16'h5432; b = 16'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      @(posedge clk); #1;
      lat++;
      a = 16'h9999; b = 16'h0000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat++;
      a = 16'h7777; b = 16'h3333;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total_cnt++; if (lat  !== 5)        $display("FAIL ignore latency got %0d exp 5", lat); else pass_cnt++;
      total_cnt++; if (diff !== 16'h4198) $display("FAIL ignore diff got %h exp 4198", diff); else pass_cnt++;
      total_cnt++; if (neg  !== 1'b0)     $display("FAIL ignore neg got %b exp 0", neg); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int lat, bcyc;
      do_op(16'h0050, 16'h0020, lat, bcyc);
      total_cnt++; if (diff !== 16'h0030) $display("FAIL b2b first diff got %h exp 0030", diff); else pass_cnt++;
      do_op(16'h0020, 16'h0050, lat, bcyc);
      total_cnt++; if (lat  !== 9)        $display("FAIL b2b second latency got %0d exp 9", lat); else pass_cnt++;
      total_cnt++; if (bcyc !== 8)        $display("FAIL b2b second busy cycles got %0d exp 8", bcyc); else pass_cnt++;
      total_cnt++; if (diff !== 16'h0030) $display("FAIL b2b second diff got %h exp 0030", diff); else pass_cnt++;
      total_cnt++; if (neg  !== 1'b1)     $display("FAIL b2b second neg got %b exp 1", neg); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_neg;
      int seen_done;
      a = 16'h1234; b = 16'h5432; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total_cnt++; if (busy !== 1'b1) $display("FAIL rstneg busy before got %b exp 1", busy); else pass_cnt++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total_cnt++; if (busy !== 1'b0)     $display("FAIL rstneg busy got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0)     $display("FAIL rstneg done got %b exp 0", done); else pass_cnt++;
      total_cnt++; if (neg  !== 1'b0)     $display("FAIL rstneg neg got %b exp 0", neg); else pass_cnt++;
      total_cnt++; if (err  !== 1'b0)     $display("FAIL rstneg err got %b exp 0", err); else pass_cnt++;
      total_cnt++; if (diff !== 16'h0000) $display("FAIL rstneg diff got %h exp 0000", diff); else pass_cnt++;
      seen_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen_done++;
      end
      total_cnt++; if (seen_done !== 0) $display("FAIL rstneg stray done got %0d pulses exp 0", seen_done); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_err();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_neg();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
